// File: rtl/rxshift_pkg.sv
// Shared types, limits and helpers for the configurable UART receive path.
package rxshift_pkg;

  localparam int unsigned MIN_BAUD = 4;
  localparam int unsigned MIN_BITS = 5;
  localparam int unsigned PAR_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE,
    BRK_WAIT
  } rx_state_e;

  // High when the received parity bit does not match the word under the chosen mode.
  function automatic logic parity_mismatch(input logic [PAR_W-1:0] data,
                                           input logic             p,
                                           input logic             odd);
    return (^data) ^ p ^ odd;
  endfunction

endpackage

// File: rtl/rxshift_cfg_if.sv
// Configuration and received-word bus between the Rx deserialiser and its consumer.
interface rxshift_cfg_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BAUD_W = 14
);

  logic              i_Enable;
  logic [BAUD_W-1:0] i_Baud;
  logic [3:0]        i_Data_Bits;
  logic              i_Parity_En;
  logic              i_Parity_Odd;
  logic              i_Two_Stop;
  logic [DATA_W-1:0] o_Data;
  logic              o_Valid;
  logic              o_Parity_Err;
  logic              o_Frame_Err;
  logic              o_Busy;

  modport master (
    output i_Enable, i_Baud, i_Data_Bits, i_Parity_En, i_Parity_Odd, i_Two_Stop,
    input  o_Data, o_Valid, o_Parity_Err, o_Frame_Err, o_Busy
  );

  modport slave (
    input  i_Enable, i_Baud, i_Data_Bits, i_Parity_En, i_Parity_Odd, i_Two_Stop,
    output o_Data, o_Valid, o_Parity_Err, o_Frame_Err, o_Busy
  );

endinterface

// File: rtl/rxshift_cfg_rx_sync.sv
// Two-flop synchroniser for an asynchronous idle-high serial line.
module rx_sync (
  input  logic i_Pclk,
  input  logic i_Rst_n,
  input  logic i_D,
  output logic o_Q
);

  logic meta;

  // Resets to the idle-high level so no false start is seen after reset.
  always_ff @(posedge i_Pclk) begin
    if (!i_Rst_n) begin
      meta <= 1'b1;
      o_Q  <= 1'b1;
    end else begin
      meta <= i_D;
      o_Q  <= meta;
    end
  end

endmodule

// File: rtl/rxshift_cfg.sv
// Runtime-configurable UART receive deserialiser (5..DATA_W bits, parity, 1/2 stop).
module rxshift_cfg
  import rxshift_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BAUD_W = 14
) (
  input  logic          i_Pclk,
  input  logic          i_Rst_n,
  input  logic          i_Rx_Serial,
  rxshift_cfg_if.slave  bus
);

  localparam int unsigned IDX_W = 4;

  rx_state_e         state;
  logic              rx_s;
  logic [BAUD_W-1:0] cnt;
  logic [BAUD_W-1:0] b_q;
  logic [IDX_W-1:0]  n_q;
  logic              pen_q;
  logic              odd_q;
  logic              two_q;
  logic [IDX_W-1:0]  bit_idx;
  logic              stop_idx;
  logic [DATA_W-1:0] shreg;
  logic              perr_q;
  logic              ferr_q;

  logic [BAUD_W-1:0] baud_cl;
  logic [IDX_W-1:0]  bits_cl;
  logic [BAUD_W-1:0] last_cnt;
  logic [BAUD_W-1:0] half_cnt;
  logic              bit_tick;
  logic              bit_last;

  rx_sync u_rx_sync (
    .i_Pclk  (i_Pclk),
    .i_Rst_n (i_Rst_n),
    .i_D     (i_Rx_Serial),
    .o_Q     (rx_s)
  );

  // Clamp the live configuration so a captured frame always makes progress.
  assign baud_cl = (bus.i_Baud < BAUD_W'(MIN_BAUD)) ? BAUD_W'(MIN_BAUD) : bus.i_Baud;
  assign bits_cl = (bus.i_Data_Bits < IDX_W'(MIN_BITS) || bus.i_Data_Bits > IDX_W'(DATA_W))
                   ? IDX_W'(DATA_W) : bus.i_Data_Bits;

  // Bit timing derived from the captured divisor only.
  assign last_cnt = b_q - BAUD_W'(1);
  assign half_cnt = last_cnt >> 1;
  assign bit_tick = (cnt == last_cnt);
  assign bit_last = (bit_idx == n_q - IDX_W'(1));

  // Frame state machine with registered word, flags and status.
  always_ff @(posedge i_Pclk) begin
    if (!i_Rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      b_q              <= BAUD_W'(MIN_BAUD);
      n_q              <= IDX_W'(DATA_W);
      pen_q            <= 1'b0;
      odd_q            <= 1'b0;
      two_q            <= 1'b0;
      bit_idx          <= '0;
      stop_idx         <= 1'b0;
      shreg            <= '0;
      perr_q           <= 1'b0;
      ferr_q           <= 1'b0;
      bus.o_Data       <= '0;
      bus.o_Valid      <= 1'b0;
      bus.o_Parity_Err <= 1'b0;
      bus.o_Frame_Err  <= 1'b0;
      bus.o_Busy       <= 1'b0;
    end else begin
      bus.o_Valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_Enable && !rx_s) begin
            b_q        <= baud_cl;
            n_q        <= bits_cl;
            pen_q      <= bus.i_Parity_En;
            odd_q      <= bus.i_Parity_Odd;
            two_q      <= bus.i_Two_Stop;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shreg      <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            bus.o_Busy <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          if (cnt == half_cnt) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              bus.o_Busy <= 1'b0;
              state      <= IDLE;
            end
          end else begin
            cnt <= cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (bit_tick) begin
            cnt   <= '0;
            shreg <= shreg | (DATA_W'(rx_s) << bit_idx);
            if (bit_last) begin
              bit_idx <= '0;
              state   <= pen_q ? PARITY : STOP;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + BAUD_W'(1);
          end
        end
        PARITY: begin
          if (bit_tick) begin
            cnt    <= '0;
            perr_q <= parity_mismatch(PAR_W'(shreg), rx_s, odd_q);
            state  <= STOP;
          end else begin
            cnt <= cnt + BAUD_W'(1);
          end
        end
        STOP: begin
          if (bit_tick) begin
            cnt <= '0;
            if (!rx_s) begin
              ferr_q <= 1'b1;
            end
            if (two_q && !stop_idx) begin
              stop_idx <= 1'b1;
            end else begin
              state <= DONE;
            end
          end else begin
            cnt <= cnt + BAUD_W'(1);
          end
        end
        DONE: begin
          bus.o_Data       <= shreg;
          bus.o_Parity_Err <= perr_q;
          bus.o_Frame_Err  <= ferr_q;
          bus.o_Valid      <= 1'b1;
          if (ferr_q) begin
            state <= BRK_WAIT;
          end else begin
            bus.o_Busy <= 1'b0;
            state      <= IDLE;
          end
        end
        BRK_WAIT: begin
          // A held-low line must return high before another start is armed.
          if (rx_s) begin
            bus.o_Busy <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          bus.o_Busy <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
